// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared state encoding and bubble constant for pipe_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Every empty slot holds this value replicated across ctrl and data.
    localparam logic c_BUBBLE_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Brief    : One ctrl+data storage entry with valid bit; clear forces a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    import pipe_pkg::*;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{c_BUBBLE_BIT}};
            r_data  <= {DATA_W{c_BUBBLE_BIT}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline stage register, optional skid entry, flush,
//            saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              refresh,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_pkg::*;

    pipe_state_t       r_state;
    pipe_state_t       w_stateNext;
    logic              w_accept;
    logic              w_pop;
    logic              w_mainLoad;
    logic              w_mainClear;
    logic              w_mainFromSkid;
    logic              w_skidLoad;
    logic              w_skidClear;
    logic              w_mainValid;
    logic              w_skidValid;
    logic [CTRL_W-1:0] w_skidCtrl;
    logic [DATA_W-1:0] w_skidData;
    logic [CTRL_W-1:0] w_mainCtrlIn;
    logic [DATA_W-1:0] w_mainDataIn;
    logic [CNT_W-1:0]  r_stallCnt;

    assign out_valid = w_mainValid;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = w_mainValid && out_ready;

    always_ff @(posedge clk) begin
        if (refresh) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_mainLoad     = 1'b0;
        w_mainClear    = 1'b0;
        w_mainFromSkid = 1'b0;
        w_skidLoad     = 1'b0;
        w_skidClear    = 1'b0;
        if (flush) begin
            w_stateNext = EMPTY;
            w_mainClear = 1'b1;
            w_skidClear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_stateNext = ONE;
                        w_mainLoad  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_mainLoad = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_stateNext = TWO;
                        w_skidLoad  = 1'b1;
                    end else if (w_pop) begin
                        w_stateNext = EMPTY;
                        w_mainClear = 1'b1;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_stateNext    = ONE;
                        w_mainLoad     = 1'b1;
                        w_mainFromSkid = 1'b1;
                        w_skidClear    = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = EMPTY;
                    w_mainClear = 1'b1;
                    w_skidClear = 1'b1;
                end
            endcase
        end
    end

    assign w_mainCtrlIn = w_mainFromSkid ? w_skidCtrl : in_ctrl;
    assign w_mainDataIn = w_mainFromSkid ? w_skidData : in_data;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (refresh),
        .i_load  (w_mainLoad),
        .i_clear (w_mainClear),
        .i_ctrl  (w_mainCtrlIn),
        .i_data  (w_mainDataIn),
        .o_valid (w_mainValid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst     (refresh),
                .i_load  (w_skidLoad),
                .i_clear (w_skidClear),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skidValid),
                .o_ctrl  (w_skidCtrl),
                .o_data  (w_skidData)
            );
            // Skid occupancy is a flop, so in_ready never sees out_ready.
            assign in_ready = !w_skidValid;
        end else begin : g_noSkid
            assign w_skidValid = 1'b0;
            assign w_skidCtrl  = '0;
            assign w_skidData  = '0;
            assign in_ready    = !w_mainValid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (refresh) begin
            r_stallCnt <= '0;
        end else if (w_mainValid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench: DUT0 SKID=1, DUT1 SKID=0, DUT2 SKID=1 CNT_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       inValid, outReady, refresh, flush;
    logic [2:0][15:0] inCtrl;
    logic [2:0][31:0] inData;
    wire  [2:0]       inReady, outValid;
    wire  [2:0][15:0] outCtrl;
    wire  [2:0][31:0] outData;
    wire  [2:0][15:0] stallCnt;
    wire  [3:0]       cntC;

    assign stallCnt[2] = {12'd0, cntC};

    int nChecks = 0;
    int nFail   = 0;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(16)) dutA (
        .clk(clk), .refresh(refresh[0]), .flush(flush[0]),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_ctrl(inCtrl[0]), .in_data(inData[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_ctrl(outCtrl[0]),
        .out_data(outData[0]), .stall_cnt(stallCnt[0]));

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .refresh(refresh[1]), .flush(flush[1]),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_ctrl(inCtrl[1]), .in_data(inData[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_ctrl(outCtrl[1]),
        .out_data(outData[1]), .stall_cnt(stallCnt[1]));

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(4)) dutC (
        .clk(clk), .refresh(refresh[2]), .flush(flush[2]),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_ctrl(inCtrl[2]), .in_data(inData[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_ctrl(outCtrl[2]),
        .out_data(outData[2]), .stall_cnt(cntC));

    // Reference model: an ordered queue of {ctrl,data} per DUT plus a counter.
    logic [47:0] mq[3][$];
    logic [15:0] mcnt[3];

    function automatic logic [15:0] cntMax(int i);
        return (i == 2) ? 16'd15 : 16'hFFFF;
    endfunction

    function automatic logic expReady(int i);
        if (i != 1) return mq[i].size() < 2;
        return (mq[i].size() == 0) || outReady[i];
    endfunction

    function automatic logic [65:0] modelVec(int i);
        logic [47:0] h;
        h = (mq[i].size() > 0) ? mq[i][0] : 48'd0;
        return {expReady(i), mq[i].size() > 0, h, mcnt[i]};
    endfunction

    function automatic logic [65:0] dutVec(int i);
        return {inReady[i], outValid[i], outCtrl[i], outData[i], stallCnt[i]};
    endfunction

    task automatic modelStep(int i);
        logic rdy, v;
        if (refresh[i]) begin
            mq[i]   = {};
            mcnt[i] = 16'd0;
        end else begin
            rdy = expReady(i);
            v   = mq[i].size() > 0;
            if (v && !outReady[i] && mcnt[i] != cntMax(i)) mcnt[i] = mcnt[i] + 16'd1;
            if (flush[i]) begin
                mq[i] = {};
            end else begin
                if (v && outReady[i]) void'(mq[i].pop_front());
                if (inValid[i] && rdy) mq[i].push_back({inCtrl[i], inData[i]});
            end
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) modelStep(i);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] c,
                         input logic [31:0] d, input logic r);
        inValid[i]  = v;
        inCtrl[i]   = c;
        inData[i]   = d;
        outReady[i] = r;
    endtask

    task automatic idleAll();
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 16'd0, 32'd0, 1'b0);
            flush[i]   = 1'b0;
            refresh[i] = 1'b0;
        end
    endtask

    task automatic doReset();
        idleAll();
        refresh = 3'b111;
        tick();
        tick();
        refresh = 3'b000;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        expV;
        logic [31:0] expD;
        logic        expRdy;
    } vec_t;

    vec_t tbl[9];
    logic [2:0] held;

    initial begin
        tbl[0] = '{1'b1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1};
        tbl[1] = '{1'b1, 32'd2, 1'b1, 1'b1, 32'd1, 1'b1};
        tbl[2] = '{1'b1, 32'd3, 1'b1, 1'b1, 32'd2, 1'b1};
        tbl[3] = '{1'b1, 32'd4, 1'b1, 1'b1, 32'd3, 1'b1};
        tbl[4] = '{1'b1, 32'd5, 1'b1, 1'b1, 32'd4, 1'b1};
        tbl[5] = '{1'b1, 32'd6, 1'b1, 1'b1, 32'd5, 1'b1};
        tbl[6] = '{1'b1, 32'd7, 1'b1, 1'b1, 32'd6, 1'b1};
        tbl[7] = '{1'b1, 32'd8, 1'b1, 1'b1, 32'd7, 1'b1};
        tbl[8] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 1'b1};

        // Reset with a live upstream offer.
        idleAll();
        refresh = 3'b111;
        for (int i = 0; i < 3; i++) drive(i, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        tick();
        idleAll();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_valid%0d", i), outValid[i], 1'b0);
            chk($sformatf("reset_ctrl%0d", i), outCtrl[i], 16'd0);
            chk($sformatf("reset_data%0d", i), outData[i], 32'd0);
            chk($sformatf("reset_cnt%0d", i), stallCnt[i], 16'd0);
            chk($sformatf("reset_ready%0d", i), inReady[i], 1'b1);
        end

        // Streaming through the skid configuration.
        for (int k = 0; k < 9; k++) begin
            drive(0, tbl[k].v, tbl[k].d[15:0] ^ 16'hA5A5, tbl[k].d, tbl[k].r);
            #1;
            chk($sformatf("stream%0d_valid", k), outValid[0], tbl[k].expV);
            chk($sformatf("stream%0d_data", k), outData[0], tbl[k].expD);
            chk($sformatf("stream%0d_ctrl", k), outCtrl[0],
                tbl[k].expV ? (tbl[k].expD[15:0] ^ 16'hA5A5) : 16'd0);
            chk($sformatf("stream%0d_ready", k), inReady[0], tbl[k].expRdy);
            tick();
        end

        // Skid backpressure: 10, 11, 12 with out_ready dropping.
        doReset();
        drive(0, 1'b1, 16'h10A, 32'd10, 1'b1); #1;
        chk("skid_c0_ready", inReady[0], 1'b1);
        tick();
        drive(0, 1'b1, 16'h10B, 32'd11, 1'b0); #1;
        chk("skid_c1_data", outData[0], 32'd10);
        chk("skid_c1_ready", inReady[0], 1'b1);
        tick();
        drive(0, 1'b1, 16'h10C, 32'd12, 1'b0); #1;
        chk("skid_c2_data", outData[0], 32'd10);
        chk("skid_c2_ready", inReady[0], 1'b0);
        chk("skid_c2_cnt", stallCnt[0], 16'd1);
        tick();
        drive(0, 1'b1, 16'h10C, 32'd12, 1'b1); #1;
        chk("skid_c3_data", outData[0], 32'd10);
        chk("skid_c3_ready", inReady[0], 1'b0);
        chk("skid_c3_cnt", stallCnt[0], 16'd2);
        tick();
        #1;
        chk("skid_c4_data", outData[0], 32'd11);
        chk("skid_c4_ctrl", outCtrl[0], 16'h10B);
        chk("skid_c4_ready", inReady[0], 1'b1);
        tick();
        drive(0, 1'b0, 16'd0, 32'd0, 1'b1); #1;
        chk("skid_c5_data", outData[0], 32'd12);
        chk("skid_c5_cnt", stallCnt[0], 16'd2);
        tick();
        chk("skid_c6_valid", outValid[0], 1'b0);
        chk("skid_c6_data", outData[0], 32'd0);

        // Flush in TWO with a simultaneous pop and an offered entry.
        doReset();
        drive(0, 1'b1, 16'h114, 32'd20, 1'b0);
        tick();
        drive(0, 1'b1, 16'h115, 32'd21, 1'b0); #1;
        chk("flush_c1_data", outData[0], 32'd20);
        tick();
        drive(0, 1'b1, 16'h116, 32'd22, 1'b1);
        flush[0] = 1'b1; #1;
        chk("flush_c2_ready", inReady[0], 1'b0);
        chk("flush_c2_cnt", stallCnt[0], 16'd1);
        tick();
        flush[0] = 1'b0;
        drive(0, 1'b0, 16'd0, 32'd0, 1'b1); #1;
        chk("flush_c3_valid", outValid[0], 1'b0);
        chk("flush_c3_ctrl", outCtrl[0], 16'd0);
        chk("flush_c3_data", outData[0], 32'd0);
        chk("flush_c3_ready", inReady[0], 1'b1);
        chk("flush_c3_cnt", stallCnt[0], 16'd1);
        tick();
        chk("flush_c4_valid", outValid[0], 1'b0);
        // Flush from ONE while the offer is accepted: the offer is dropped.
        drive(0, 1'b1, 16'h117, 32'd23, 1'b0);
        tick();
        drive(0, 1'b1, 16'h118, 32'd24, 1'b0);
        flush[0] = 1'b1; #1;
        chk("flush_one_ready", inReady[0], 1'b1);
        tick();
        flush[0] = 1'b0;
        drive(0, 1'b0, 16'd0, 32'd0, 1'b1); #1;
        chk("flush_one_valid", outValid[0], 1'b0);
        tick();
        chk("flush_one_after", outValid[0], 1'b0);

        // Plain register (no skid): combinational in_ready.
        doReset();
        drive(1, 1'b1, 16'h11E, 32'd30, 1'b0); #1;
        chk("noskid_c0_ready", inReady[1], 1'b1);
        tick();
        drive(1, 1'b1, 16'h11F, 32'd31, 1'b0); #1;
        chk("noskid_c1_ready", inReady[1], 1'b0);
        chk("noskid_c1_data", outData[1], 32'd30);
        tick();
        drive(1, 1'b1, 16'h11F, 32'd31, 1'b1); #1;
        chk("noskid_c2_ready", inReady[1], 1'b1);
        tick();
        drive(1, 1'b0, 16'd0, 32'd0, 1'b1); #1;
        chk("noskid_c3_data", outData[1], 32'd31);
        chk("noskid_c3_valid", outValid[1], 1'b1);
        chk("noskid_c3_cnt", stallCnt[1], 16'd1);
        tick();
        chk("noskid_c4_valid", outValid[1], 1'b0);

        // Saturation of the 4-bit counter, then refresh.
        doReset();
        drive(2, 1'b1, 16'h1, 32'd1, 1'b0);
        tick();
        drive(2, 1'b0, 16'd0, 32'd0, 1'b0);
        repeat (20) tick();
        chk("sat_cnt", stallCnt[2], 16'd15);
        chk("sat_valid", outValid[2], 1'b1);
        refresh[2] = 1'b1;
        tick();
        refresh[2] = 1'b0;
        #1;
        chk("sat_refresh_cnt", stallCnt[2], 16'd0);

        // Randomized traffic against the queue model.
        doReset();
        held = 3'b000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                outReady[i] = ($urandom_range(0, 9) < 7);
                flush[i]    = ($urandom_range(0, 15) == 0);
                refresh[i]  = ($urandom_range(0, 49) == 0);
                if (!held[i]) begin
                    inValid[i] = ($urandom_range(0, 9) < 7);
                    inCtrl[i]  = 16'($urandom);
                    inData[i]  = $urandom;
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rand_dut%0d_cyc%0d", i, cyc), dutVec(i), modelVec(i));
                held[i] = inValid[i] && !expReady(i);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
